memory_access: RTL and testbench

- Pipeline stage directly upstream of the register-write / PC-generate stage.
- Accepts one instruction token per `distinct` pulse from the execute stage and performs at most one data-memory read or write against a synchronous BRAM with fixed read latency.
- Forwards `read_data` plus all write-back and PC-generation fields, emitting a single-cycle `distinct_next` token when its outputs are valid.

---
 rtl/memory_access.sv | 175 +++++++++++++++++
 tb/tb_memory_access.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access.sv
`default_nettype none
// ============================================================================
//  Module   : memory_access
//  Purpose  : Memory stage; one data-memory access per token, then forwards
//             the write-back / PC-generate fields with a one-cycle token.
//  Revision : 1.0  initial release
// ============================================================================
module memory_access #(
  parameter int DATA_MEM_WIDTH = 10,
  parameter int INST_MEM_WIDTH = 5,
  parameter int MEM_LATENCY    = 1
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic                      distinct,
  input  logic                      AorF,
  input  logic                      RegWrite,
  input  logic                      MemRead,
  input  logic                      MemWrite,
  input  logic [1:0]                MemtoReg,
  input  logic [1:0]                Branch,
  input  logic                      UARTtoReg,
  input  logic [31:0]               alu_result,
  input  logic [31:0]               write_data,
  input  logic [31:0]               register_data,
  input  logic [4:0]                rd,
  input  logic [25:0]               inst_index,
  input  logic [INST_MEM_WIDTH-1:0] pc,
  input  logic [INST_MEM_WIDTH-1:0] pc1,
  input  logic [INST_MEM_WIDTH-1:0] pc2,
  input  logic [31:0]               mem_rdata,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [DATA_MEM_WIDTH-1:0] mem_addr,
  output logic [31:0]               mem_wdata,
  output logic                      busy,
  output logic                      distinct_next,
  output logic [31:0]               read_data,
  output logic                      AorF_next,
  output logic                      RegWrite_next,
  output logic [1:0]                MemtoReg_next,
  output logic [1:0]                Branch_next,
  output logic                      UARTtoReg_next,
  output logic [31:0]               alu_result_next,
  output logic [31:0]               register_data_next,
  output logic [4:0]                rd_next,
  output logic [25:0]               inst_index_next,
  output logic [INST_MEM_WIDTH-1:0] pc_next,
  output logic [INST_MEM_WIDTH-1:0] pc1_next,
  output logic [INST_MEM_WIDTH-1:0] pc2_next
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDONE = 2'd1,
    RWAIT = 2'd2
  } state_t;

  localparam logic [2:0] c_last_wait = 3'(MEM_LATENCY);

  state_t     r_state;
  state_t     w_state_next;
  logic [2:0] r_count;
  logic       w_accept;

  // busy also covers the no-memory token's cycle, which stays in IDLE
  assign w_accept = distinct && (r_state == IDLE) && !busy;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (MemWrite)     w_state_next = WDONE;
          else if (MemRead) w_state_next = RWAIT;
          else              w_state_next = IDLE;
        end
      end
      WDONE:   w_state_next = IDLE;
      RWAIT:   if (r_count == c_last_wait) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_count            <= 3'd0;
      mem_en             <= 1'b0;
      mem_we             <= 1'b0;
      mem_addr           <= '0;
      mem_wdata          <= 32'd0;
      busy               <= 1'b0;
      distinct_next      <= 1'b0;
      read_data          <= 32'd0;
      AorF_next          <= 1'b0;
      RegWrite_next      <= 1'b0;
      MemtoReg_next      <= 2'b00;
      Branch_next        <= 2'b11;
      UARTtoReg_next     <= 1'b0;
      alu_result_next    <= 32'd0;
      register_data_next <= 32'd0;
      rd_next            <= 5'd0;
      inst_index_next    <= 26'd0;
      pc_next            <= '0;
      pc1_next           <= '0;
      pc2_next           <= '0;
    end else begin
      distinct_next <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            AorF_next          <= AorF;
            RegWrite_next      <= RegWrite;
            MemtoReg_next      <= MemtoReg;
            Branch_next        <= Branch;
            UARTtoReg_next     <= UARTtoReg;
            alu_result_next    <= alu_result;
            register_data_next <= register_data;
            rd_next            <= rd;
            inst_index_next    <= inst_index;
            pc_next            <= pc;
            pc1_next           <= pc1;
            pc2_next           <= pc2;
            mem_addr           <= alu_result[DATA_MEM_WIDTH-1:0];
            mem_wdata          <= write_data;
            busy               <= 1'b1;
            r_count            <= 3'd0;
            if (MemWrite) begin
              mem_en <= 1'b1;
              mem_we <= 1'b1;
            end else if (MemRead) begin
              mem_en <= 1'b1;
              mem_we <= 1'b0;
            end else begin
              read_data     <= 32'd0;
              distinct_next <= 1'b1;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        WDONE: begin
          mem_en        <= 1'b0;
          mem_we        <= 1'b0;
          read_data     <= 32'd0;
          distinct_next <= 1'b1;
          busy          <= 1'b0;
        end
        RWAIT: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          // the edge after MEM_LATENCY counted cycles sees valid BRAM data
          if (r_count == c_last_wait) begin
            read_data     <= mem_rdata;
            distinct_next <= 1'b1;
            busy          <= 1'b0;
          end else begin
            r_count <= r_count + 3'd1;
          end
        end
        default: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_access.sv
`default_nettype none
// ============================================================================
//  Module   : tb_memory_access
//  Purpose  : Self-checking bench; two instances (read latency 1 and 3) share
//             stimulus and are compared against a token-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_memory_access;

  typedef struct packed {
    logic        aorf;
    logic        regw;
    logic [1:0]  m2r;
    logic [1:0]  br;
    logic        uart;
    logic [31:0] alu;
    logic [31:0] regd;
    logic [4:0]  rd;
    logic [25:0] idx;
    logic [4:0]  pc;
    logic [4:0]  pc1;
    logic [4:0]  pc2;
    logic        mr;
    logic        mw;
    logic [31:0] wd;
  } tok_t;

  logic clk = 1'b0;
  logic reset;
  logic distinct;
  tok_t din;

  logic        mem_en   [2];
  logic        mem_we   [2];
  logic [9:0]  mem_addr [2];
  logic [31:0] mem_wdata[2];
  logic [31:0] mem_rdata[2];
  logic        busy     [2];
  logic        dnext    [2];
  logic [31:0] rdata    [2];
  logic        aorf_n   [2];
  logic        regw_n   [2];
  logic [1:0]  m2r_n    [2];
  logic [1:0]  br_n     [2];
  logic        uart_n   [2];
  logic [31:0] alu_n    [2];
  logic [31:0] regd_n   [2];
  logic [4:0]  rd_n     [2];
  logic [25:0] idx_n    [2];
  logic [4:0]  pc_n     [2];
  logic [4:0]  pc1_n    [2];
  logic [4:0]  pc2_n    [2];
  logic [116:0] fld     [2];

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] ref_mem [1024];

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    if (i == 3) return 32'h1234_5678;
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  function automatic int lat(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  function automatic logic [116:0] pack(input tok_t t);
    return {t.aorf, t.regw, t.m2r, t.br, t.uart, t.alu, t.regd, t.rd, t.idx,
            t.pc, t.pc1, t.pc2};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [31:0] bram [1024];
    logic [31:0] pipe [LAT];

    memory_access #(.DATA_MEM_WIDTH(10), .INST_MEM_WIDTH(5), .MEM_LATENCY(LAT)) u_dut (
      .CLK(clk), .reset(reset), .distinct(distinct),
      .AorF(din.aorf), .RegWrite(din.regw), .MemRead(din.mr), .MemWrite(din.mw),
      .MemtoReg(din.m2r), .Branch(din.br), .UARTtoReg(din.uart),
      .alu_result(din.alu), .write_data(din.wd), .register_data(din.regd),
      .rd(din.rd), .inst_index(din.idx), .pc(din.pc), .pc1(din.pc1), .pc2(din.pc2),
      .mem_rdata(mem_rdata[g]), .mem_en(mem_en[g]), .mem_we(mem_we[g]),
      .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]), .busy(busy[g]),
      .distinct_next(dnext[g]), .read_data(rdata[g]),
      .AorF_next(aorf_n[g]), .RegWrite_next(regw_n[g]), .MemtoReg_next(m2r_n[g]),
      .Branch_next(br_n[g]), .UARTtoReg_next(uart_n[g]), .alu_result_next(alu_n[g]),
      .register_data_next(regd_n[g]), .rd_next(rd_n[g]), .inst_index_next(idx_n[g]),
      .pc_next(pc_n[g]), .pc1_next(pc1_n[g]), .pc2_next(pc2_n[g])
    );

    initial begin
      for (int i = 0; i < 1024; i++) bram[i] = init_word(i);
      for (int s = 0; s < LAT; s++) pipe[s] = 32'd0;
    end

    // synchronous BRAM with LAT cycles of read latency
    always @(posedge clk) begin
      if (mem_en[g]) begin
        if (mem_we[g]) bram[mem_addr[g]] <= mem_wdata[g];
        pipe[0] <= bram[mem_addr[g]];
      end
      for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
    end

    assign mem_rdata[g] = pipe[LAT-1];
    assign fld[g] = {aorf_n[g], regw_n[g], m2r_n[g], br_n[g], uart_n[g], alu_n[g],
                     regd_n[g], rd_n[g], idx_n[g], pc_n[g], pc1_n[g], pc2_n[g]};
  end

  task automatic check(input string tag, input int g, input logic [127:0] obs,
                       input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[L%0d]: observed %0h expected %0h", tag, lat(g), obs, exp);
    end
  endtask

  function automatic tok_t reset_tok();
    tok_t t = '0;
    t.br = 2'b11;
    return t;
  endfunction

  task automatic check_reset_state(input string tag);
    for (int g = 0; g < 2; g++) begin
      check({tag, "_fields"}, g, 128'(fld[g]), 128'(pack(reset_tok())));
      check({tag, "_ctrl"}, g,
            128'({mem_en[g], mem_we[g], mem_addr[g], mem_wdata[g], busy[g],
                  dnext[g], rdata[g]}), 128'd0);
    end
  endtask

  task automatic run_token(input tok_t t, input bit inject);
    bit          is_st = t.mw;
    bit          is_ld = t.mr && !t.mw;
    int          pulses[2], pcyc[2], nbusy[2], nen[2], nwe[2], nbad[2];
    int          exp_p, exp_b;
    logic [31:0] exp_rd;
    tok_t        junk;
    exp_rd = is_ld ? ref_mem[t.alu[9:0]] : 32'd0;
    for (int g = 0; g < 2; g++) begin
      pulses[g] = 0; pcyc[g] = -1; nbusy[g] = 0; nen[g] = 0; nwe[g] = 0; nbad[g] = 0;
    end
    @(negedge clk);
    din = t;
    distinct = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (dnext[g]) begin pulses[g]++; pcyc[g] = k; end
        if (busy[g]) nbusy[g]++;
        if (mem_en[g]) nen[g]++;
        if (mem_we[g]) nwe[g]++;
        if (mem_we[g] && !mem_en[g]) nbad[g]++;
      end
      if (k == 0) distinct = 1'b0;
      if (inject && k == 1) begin
        junk = t;
        junk.mw = 1'b1; junk.rd = ~t.rd; junk.alu = t.alu ^ 32'h55;
        junk.wd = ~t.wd; junk.pc = ~t.pc;
        din = junk;
        distinct = 1'b1;
      end
      if (inject && k == 2) distinct = 1'b0;
    end
    for (int g = 0; g < 2; g++) begin
      exp_p = is_ld ? lat(g) + 1 : (is_st ? 1 : 0);
      exp_b = (exp_p == 0) ? 1 : exp_p;
      check("pulse_count", g, 128'(pulses[g]), 128'(1));
      check("pulse_cycle", g, 128'(pcyc[g]), 128'(exp_p));
      check("busy_cycles", g, 128'(nbusy[g]), 128'(exp_b));
      check("en_cycles", g, 128'(nen[g]), 128'((is_ld || is_st) ? 1 : 0));
      check("we_cycles", g, 128'(nwe[g]), 128'(is_st ? 1 : 0));
      check("we_wo_en", g, 128'(nbad[g]), 128'(0));
      check("read_data", g, 128'(rdata[g]), 128'(exp_rd));
      check("fields", g, 128'(fld[g]), 128'(pack(t)));
      check("mem_addr", g, 128'(mem_addr[g]), 128'(t.alu[9:0]));
      check("mem_wdata", g, 128'(mem_wdata[g]), 128'(t.wd));
    end
    if (is_st) ref_mem[t.alu[9:0]] = t.wd;
  endtask

  function automatic tok_t rand_tok();
    tok_t t;
    t.aorf = 1'($urandom);  t.regw = 1'($urandom);
    t.m2r  = 2'($urandom);  t.br   = 2'($urandom);
    t.uart = 1'($urandom);  t.regd = $urandom;
    t.rd   = 5'($urandom);  t.idx  = 26'($urandom);
    t.pc   = 5'($urandom);  t.pc1  = 5'($urandom);  t.pc2 = 5'($urandom);
    t.wd   = $urandom;
    t.alu  = {$urandom_range(0, 4194303), 10'($urandom_range(0, 15))};
    t.mr   = 1'($urandom);  t.mw   = ($urandom_range(0, 2) == 0);
    return t;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    tok_t t;
    int   hits;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    reset = 1'b1;
    distinct = 1'b0;
    din = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check_reset_state("idle");
    end

    t = '0; t.rd = 5'd5; t.regw = 1'b1; t.alu = 32'h0000_0042; t.pc = 5'd7;
    run_token(t, 1'b0);

    t = '0; t.mr = 1'b1; t.alu = 32'h0000_0003; t.rd = 5'd9; t.m2r = 2'b01;
    run_token(t, 1'b0);

    t = '0; t.mw = 1'b1; t.alu = 32'h0000_0403; t.wd = 32'hDEAD_BEEF; t.br = 2'b10;
    run_token(t, 1'b0);

    t = '0; t.mr = 1'b1; t.alu = 32'hFFFF_FC03; t.rd = 5'd17; t.pc2 = 5'd31;
    run_token(t, 1'b1);

    // reset lands just after the first wait edge of a load
    @(negedge clk);
    din = '0; din.mr = 1'b1; din.alu = 32'h0000_0003; din.rd = 5'd3;
    distinct = 1'b1;
    @(negedge clk);
    distinct = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    #1 check_reset_state("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    hits = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) if (dnext[g]) hits++;
    end
    check("no_pulse_after_reset", 0, 128'(hits), 128'(0));

    t = rand_tok(); t.mr = 1'b1; t.mw = 1'b0;
    run_token(t, 1'b0);

    for (int n = 0; n < 30; n++) begin
      t = rand_tok();
      run_token(t, (t.mr && !t.mw) ? 1'(n % 2) : 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
